reg_readout_serializer: RTL and testbench

//  Read-side companion to the SLC-3 datapath register loaders.
//  On a start pulse it snapshots one WIDTH-bit register value (PC, IR, MDR, Rn).
//  It then shifts the value out one bit per accepted transfer on a valid/ready serial link.

---
 rtl/reg_readout_serializer_if.sv | 10 +
 rtl/reg_readout_serializer.sv | 83 ++++++++
 tb/tb_reg_readout_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_readout_serializer_if.sv
// Serial readout link: one data bit with a valid/ready handshake.
// master drives the bit stream, slave applies backpressure.
interface reg_readout_serializer_if;
   logic sout;
   logic sout_valid;
   logic sout_ready;

   modport master (output sout, output sout_valid, input sout_ready);
   modport slave  (input sout, input sout_valid, output sout_ready);
endinterface

// File: rtl/reg_readout_serializer.sv
// Snapshots one register word on start and streams it out one bit per accepted
// valid/ready transfer. It then pulses done and counts completed readouts.
module reg_readout_serializer #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             din,
   input  logic                         start,
   reg_readout_serializer_if.master     link,
   output logic                         busy,
   output logic                         done,
   output logic [7:0]                   word_count
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bitcnt;
   logic             valid_q;

   // Zero fill means shreg is all zeros once a word has been shifted out, so
   // sout reads 0 in DONE/IDLE without extra gating.
   assign link.sout       = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
   assign link.sout_valid = valid_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bitcnt     <= '0;
         valid_q    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg   <= din;
                  bitcnt  <= '0;
                  valid_q <= 1'b1;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (link.sout_ready) begin
                  if (LSB_FIRST != 0)
                     shreg <= {1'b0, shreg[WIDTH-1:1]};
                  else
                     shreg <= {shreg[WIDTH-2:0], 1'b0};
                  bitcnt <= bitcnt + CW'(1);
                  if (bitcnt == LAST_BIT) begin
                     valid_q <= 1'b0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end
               end
            end
            DONE: begin
               done       <= 1'b0;
               busy       <= 1'b0;
               word_count <= word_count + 8'd1;
               state      <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_readout_serializer.sv
// Drives an LSB-first and an MSB-first serializer with shared stimulus and
// checks both every cycle against a bit-queue model of the readout.
module tb_reg_readout_serializer;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         sout_ready;
   logic [W-1:0] din;
   logic         busy0, done0, busy1, done1;
   logic [7:0]   wc0, wc1;

   always #5 clk = ~clk;

   reg_readout_serializer_if l0 ();
   reg_readout_serializer_if l1 ();
   assign l0.sout_ready = sout_ready;
   assign l1.sout_ready = sout_ready;

   reg_readout_serializer #(.WIDTH(W), .LSB_FIRST(1)) u_lsb (
      .clk(clk), .reset(reset), .din(din), .start(start), .link(l0),
      .busy(busy0), .done(done0), .word_count(wc0));

   reg_readout_serializer #(.WIDTH(W), .LSB_FIRST(0)) u_msb (
      .clk(clk), .reset(reset), .din(din), .start(start), .link(l1),
      .busy(busy1), .done(done1), .word_count(wc1));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a readout is the queue of bits still owed in link order,
   // followed by one done cycle; word count is completed readouts mod 256.
   bit mq0[$];
   bit mq1[$];
   bit m_done = 1'b0;
   int m_wc = 0;
   int pc = 0;
   int last_cap = 0;
   int prev_cap = 0;
   int last_done_pc = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq0.delete();
         mq1.delete();
         m_done = 1'b0;
         m_wc   = 0;
      end else begin
         pc++;
         if (m_done) begin
            m_done = 1'b0;
            m_wc   = (m_wc + 1) % 256;
         end else if (mq0.size() > 0) begin
            if (sout_ready) begin
               void'(mq0.pop_front());
               void'(mq1.pop_front());
               if (mq0.size() == 0) m_done = 1'b1;
            end
         end else if (start) begin
            for (int i = 0; i < W; i++) begin
               mq0.push_back(din[i]);
               mq1.push_back(din[W-1-i]);
            end
            prev_cap = last_cap;
            last_cap = pc;
         end
      end
   end

   always @(negedge clk) begin
      bit v;
      v = (mq0.size() > 0);
      chk("sout_valid_lsb", l0.sout_valid, v);
      chk("sout_lsb", l0.sout, v ? mq0[0] : 1'b0);
      chk("busy_lsb", busy0, v | m_done);
      chk("done_lsb", done0, m_done);
      chk("word_count_lsb", wc0, m_wc);
      chk("sout_valid_msb", l1.sout_valid, v);
      chk("sout_msb", l1.sout, v ? mq1[0] : 1'b0);
      chk("busy_msb", busy1, v | m_done);
      chk("done_msb", done1, m_done);
      chk("word_count_msb", wc1, m_wc);
      if (done0 === 1'b1) last_done_pc = pc;
   end

   // Observed traffic: last W accepted bits rebuilt into a word, plus counts.
   logic [W-1:0] rx0 = '0;
   logic [W-1:0] rx1 = '0;
   int nb0 = 0;
   int dc0 = 0;
   int dc1 = 0;

   always @(posedge clk) begin
      if (l0.sout_valid === 1'b1 && sout_ready === 1'b1) begin
         rx0 = {l0.sout, rx0[W-1:1]};
         nb0++;
      end
      if (l1.sout_valid === 1'b1 && sout_ready === 1'b1)
         rx1 = {rx1[W-2:0], l1.sout};
      if (done0 === 1'b1) dc0++;
      if (done1 === 1'b1) dc1++;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating
   task automatic run_word(input logic [W-1:0] w, input int mode);
      int d;
      int k;
      d = dc0;
      k = 0;
      din   = w;
      start = 1'b1;
      tick();
      start = 1'b0;
      while (dc0 == d && k < 300) begin
         sout_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         tick();
         k++;
      end
      if (dc0 == d) chk("run_word_timeout", 0, 1);
      sout_ready = 1'b1;
      tick();
   endtask

   initial begin
      int d0, d1, n0, k;
      reset      = 1'b0;
      start      = 1'b1;
      din        = 16'hFFFF;
      sout_ready = 1'b1;
      repeat (5) begin
         tick();
         chk("reset_busy", busy0, 0);
         chk("reset_valid", l0.sout_valid, 0);
         chk("reset_done", done0, 0);
         chk("reset_word_count", wc0, 0);
      end
      reset = 1'b1;
      start = 1'b0;
      repeat (2) tick();

      d0 = dc0; d1 = dc1;
      run_word(16'hA5C3, 0);
      chk("basic_word", rx0, 16'hA5C3);
      chk("basic_done_cycle", last_done_pc - last_cap + 1, 17);
      chk("basic_done_count", dc0 - d0, 1);
      chk("basic_word_count", wc0, 1);

      d1 = dc1;
      run_word(16'h8001, 0);
      chk("msb_word", rx1, 16'h8001);
      chk("msb_done_count", dc1 - d1, 1);

      d0 = dc0; n0 = nb0;
      run_word(16'h00F0, 1);
      chk("stall_word_lsb", rx0, 16'h00F0);
      chk("stall_word_msb", rx1, 16'h00F0);
      chk("stall_transfers", nb0 - n0, 16);
      chk("stall_done_count", dc0 - d0, 1);

      d0 = dc0;
      din   = 16'h1234;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      din   = 16'hFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      k = 0;
      while (dc0 == d0 && k < 100) begin tick(); k++; end
      repeat (20) tick();
      chk("ignored_start_word", rx0, 16'h1234);
      chk("ignored_start_done_count", dc0 - d0, 1);

      d0 = dc0; n0 = nb0;
      din   = 16'h5A5A;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      reset = 1'b0;
      #1;
      chk("abort_busy", busy0, 0);
      chk("abort_valid", l0.sout_valid, 0);
      chk("abort_done", done0, 0);
      chk("abort_bits", nb0 - n0, 7);
      repeat (2) tick();
      reset = 1'b1;
      start = 1'b1;
      din   = $urandom;
      chk("abort_no_done", dc0 - d0, 0);
      k = 0;
      while (dc0 - d0 < 256 && k < 6000) begin
         din = $urandom;
         tick();
         k++;
      end
      start = 1'b0;
      if (dc0 - d0 < 256) chk("wrap_timeout", dc0 - d0, 256);
      repeat (2) tick();
      chk("wrap_word_count", wc0, 0);
      chk("wrap_done_count", dc0 - d0, 256);
      chk("back_to_back_period", last_cap - prev_cap, W + 2);

      repeat (400) begin
         start      = ($urandom_range(0, 3) == 0);
         sout_ready = $urandom_range(0, 1);
         din        = $urandom;
         tick();
      end
      start      = 1'b0;
      sout_ready = 1'b1;
      repeat (40) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
